// File: rtl/elevator_pkg.sv
// Shared types and constants for the three-floor elevator scheduler.
package elevator_pkg;

  localparam int NUM_FLOORS        = 3;
  localparam int FLOOR_W           = 2;
  localparam int TIMER_W           = 3;
  localparam int DEF_TRAVEL_TICKS  = 4;
  localparam int DEF_DOOR_TICKS    = 3;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_e;

  // Floors strictly above (up = 1) or strictly below (up = 0) floor f.
  function automatic logic [NUM_FLOORS-1:0] beyond_mask(input logic [FLOOR_W-1:0] f,
                                                        input logic up);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      m[i] = up ? (i > int'(f)) : (i < int'(f));
    end
    return m;
  endfunction

endpackage

// File: rtl/elevator_controller_button_sync.sv
// Optional 2-FF synchronizer followed by an activation-edge pulse detector.
module button_sync #(
  parameter bit SYNC       = 1'b1,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_i,
  output logic pulse_o
);

  logic level_s;
  logic prev_q;

  if (SYNC) begin : g_sync
    logic s1_q;
    logic s2_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        s1_q <= ACTIVE_LOW;
        s2_q <= ACTIVE_LOW;
      end else begin
        s1_q <= in_i;
        s2_q <= s1_q;
      end
    end
    assign level_s = ACTIVE_LOW ? ~s2_q : s2_q;
  end else begin : g_raw
    assign level_s = ACTIVE_LOW ? ~in_i : in_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level_s;
    end
  end

  assign pulse_o = level_s & ~prev_q;

endmodule

// File: rtl/elevator_controller.sv
// SCAN scheduler: latches floor calls, sequences travel and door timing on
// rising edges of the divided tick clock.
module elevator_controller
  import elevator_pkg::*;
#(
  parameter int TRAVEL_TICKS = DEF_TRAVEL_TICKS,
  parameter int DOOR_TICKS   = DEF_DOOR_TICKS
) (
  input  logic                  clk_50,
  input  logic                  reset_n,
  input  logic                  tick_clk,
  input  logic [NUM_FLOORS-1:0] button_n,
  output logic [FLOOR_W-1:0]    floor,
  output logic                  moving,
  output logic                  direction,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] requests
);

  logic [NUM_FLOORS-1:0] press_s;
  logic                  tick_rise_s;

  for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_btn
    button_sync #(.SYNC(1'b1), .ACTIVE_LOW(1'b1)) u_btn (
      .clk_i  (clk_50),
      .rst_ni (reset_n),
      .in_i   (button_n[g]),
      .pulse_o(press_s[g])
    );
  end

  // tick_clk is generated from clk_50, so only a one-cycle delay is needed.
  button_sync #(.SYNC(1'b0), .ACTIVE_LOW(1'b0)) u_tick (
    .clk_i  (clk_50),
    .rst_ni (reset_n),
    .in_i   (tick_clk),
    .pulse_o(tick_rise_s)
  );

  state_e                state_q, state_d;
  logic [FLOOR_W-1:0]    floor_q, floor_d;
  logic                  dir_q, dir_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic [NUM_FLOORS-1:0] req_q, req_d;
  logic                  moving_q, moving_d;
  logic                  door_q, door_d;

  logic [NUM_FLOORS-1:0] pend_all_s;
  logic [NUM_FLOORS-1:0] clr_s;
  logic [NUM_FLOORS-1:0] press_eff_s;
  logic [FLOOR_W-1:0]    next_floor_s;

  always_comb begin
    state_d      = state_q;
    floor_d      = floor_q;
    dir_d        = dir_q;
    timer_d      = timer_q;
    clr_s        = '0;
    press_eff_s  = press_s;
    pend_all_s   = req_q | press_s;
    next_floor_s = (state_q == MOVE_UP) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (req_q[floor_q]) begin
          state_d       = DOOR_OPEN;
          clr_s[floor_q] = 1'b1;
        end else if (|(req_q & beyond_mask(floor_q, dir_q))) begin
          state_d = (dir_q == DIR_UP) ? MOVE_UP : MOVE_DOWN;
        end else if (|req_q) begin
          dir_d   = ~dir_q;
          state_d = (dir_q == DIR_UP) ? MOVE_DOWN : MOVE_UP;
        end else begin
          state_d = IDLE;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if (tick_rise_s) begin
          if (timer_q == TIMER_W'(TRAVEL_TICKS - 1)) begin
            floor_d = next_floor_s;
            timer_d = '0;
            // A press landing in the arrival cycle is served immediately.
            if (pend_all_s[next_floor_s]) begin
              state_d             = DOOR_OPEN;
              clr_s[next_floor_s] = 1'b1;
            end else if (|(pend_all_s & beyond_mask(next_floor_s, dir_q))) begin
              state_d = state_q;
            end else begin
              state_d = IDLE;
            end
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end else begin
          timer_d = timer_q;
        end
      end
      DOOR_OPEN: begin
        if (press_s[floor_q]) begin
          timer_d              = '0;
          press_eff_s[floor_q] = 1'b0;
        end else if (tick_rise_s) begin
          if (timer_q == TIMER_W'(DOOR_TICKS - 1)) begin
            state_d = IDLE;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end else begin
          timer_d = timer_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_d    = (req_q | press_eff_s) & ~clr_s;
    moving_d = (state_d == MOVE_UP) || (state_d == MOVE_DOWN);
    door_d   = (state_d == DOOR_OPEN);
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      floor_q  <= '0;
      dir_q    <= DIR_UP;
      timer_q  <= '0;
      req_q    <= '0;
      moving_q <= 1'b0;
      door_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      floor_q  <= floor_d;
      dir_q    <= dir_d;
      timer_q  <= timer_d;
      req_q    <= req_d;
      moving_q <= moving_d;
      door_q   <= door_d;
    end
  end

  assign floor     = floor_q;
  assign moving    = moving_q;
  assign direction = dir_q;
  assign door_open = door_q;
  assign requests  = req_q;

endmodule

// File: tb/tb_elevator_controller.sv
// Directed scenarios plus randomized calls checked against a behavioural model.
module tb_elevator_controller;

  localparam int NFL    = 3;
  localparam int TRAVEL = 4;
  localparam int DOOR   = 3;

  logic       clk_50;
  logic       reset_n;
  logic       tick_clk;
  logic [2:0] button_n;
  logic [1:0] floor;
  logic       moving;
  logic       direction;
  logic       door_open;
  logic [2:0] requests;

  int checks = 0;
  int errors = 0;

  elevator_controller dut (
    .clk_50   (clk_50),
    .reset_n  (reset_n),
    .tick_clk (tick_clk),
    .button_n (button_n),
    .floor    (floor),
    .moving   (moving),
    .direction(direction),
    .door_open(door_open),
    .requests (requests)
  );

  initial begin
    clk_50 = 1'b0;
    forever #5 clk_50 = ~clk_50;
  end

  // Divided clock: toggles every 5 clk_50 cycles, changing well clear of posedge.
  initial begin
    tick_clk = 1'b0;
    forever begin
      repeat (5) @(negedge clk_50);
      #2 tick_clk = ~tick_clk;
    end
  end

  // ---------------- behavioural reference model ----------------
  int       m_floor, m_ticks;
  bit       m_dir, m_travel, m_door, t_prev;
  bit [2:0] m_pend, h1, h2, h3;
  logic [7:0] mdl_vec;
  wire  [7:0] dut_vec = {floor, moving, direction, door_open, requests};

  function automatic bit beyond(input bit [2:0] v, input int fl, input bit up);
    for (int f = 0; f < NFL; f++)
      if (v[f] && (up ? (f > fl) : (f < fl))) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_floor = 0; m_ticks = 0; m_dir = 1'b1; m_travel = 1'b0; m_door = 1'b0;
    m_pend = 3'b000; h1 = 3'b111; h2 = 3'b111; h3 = 3'b111; t_prev = 1'b0;
  endtask

  task automatic model_step();
    bit [2:0] p, clr, all;
    bit tr;
    // A low sample that follows a high sample becomes a call two edges later.
    p   = ~h2 & h3;
    tr  = tick_clk && !t_prev;
    clr = 3'b000;
    if (m_door) begin
      if (p[m_floor]) begin
        m_ticks = 0;
        p[m_floor] = 1'b0;
      end else if (tr) begin
        m_ticks++;
        if (m_ticks == DOOR) m_door = 1'b0;
      end
    end else if (m_travel) begin
      if (tr) begin
        m_ticks++;
        if (m_ticks == TRAVEL) begin
          m_floor += m_dir ? 1 : -1;
          m_ticks = 0;
          all = m_pend | p;
          if (all[m_floor]) begin
            m_travel = 1'b0; m_door = 1'b1; clr[m_floor] = 1'b1;
          end else if (!beyond(all, m_floor, m_dir)) begin
            m_travel = 1'b0;
          end
        end
      end
    end else begin
      if (m_pend[m_floor]) begin
        m_door = 1'b1; m_ticks = 0; clr[m_floor] = 1'b1;
      end else if (beyond(m_pend, m_floor, m_dir)) begin
        m_travel = 1'b1; m_ticks = 0;
      end else if (m_pend != 3'b000) begin
        m_dir = !m_dir; m_travel = 1'b1; m_ticks = 0;
      end
    end
    m_pend = (m_pend | p) & ~clr;
    h3 = h2; h2 = h1; h1 = button_n; t_prev = tick_clk;
  endtask

  initial begin
    model_reset();
    mdl_vec = {2'b00, 1'b0, 1'b1, 1'b0, 3'b000};
    forever begin
      @(posedge clk_50 or negedge reset_n);
      if (!reset_n) model_reset();
      else          model_step();
      mdl_vec = {m_floor[1:0], m_travel, m_dir, m_door, m_pend};
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic press(input logic [2:0] mask);
    @(negedge clk_50);
    button_n = button_n & ~mask;
    repeat (4) @(negedge clk_50);
    button_n = button_n | mask;
  endtask

  task automatic wait_door(input logic level);
    for (int c = 0; c < 300 && door_open !== level; c++) @(negedge clk_50);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    button_n = 3'b000;
    repeat (6) @(negedge clk_50);
    checks++; if (dut_vec !== 8'b00_0_1_0_000) begin errors++;
      $display("FAIL reset_state: got %b expected %b", dut_vec, 8'b00_0_1_0_000); end
    button_n = 3'b111;
    repeat (4) @(negedge clk_50);
    reset_n = 1'b1;
    repeat (4) @(negedge clk_50);
    checks++; if (dut_vec !== mdl_vec) begin errors++;
      $display("FAIL reset_release: got %b expected %b", dut_vec, mdl_vec); end
  endtask

  task automatic test_single_floor();
    int open_at = -1, close_at = -1;
    bit saw = 1'b0;
    @(negedge clk_50);
    button_n = 3'b110;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk_50);
      if (c == 4) button_n = 3'b111;
      if (requests[0]) saw = 1'b1;
      if (door_open && open_at < 0) open_at = c;
      if (!door_open && open_at >= 0) begin close_at = c; break; end
    end
    checks++; if (saw !== 1'b1) begin errors++;
      $display("FAIL t1_req_pulse: seen %b expected 1", saw); end
    checks++; if (open_at < 1 || open_at > 4) begin errors++;
      $display("FAIL t1_open_latency: got %0d expected 1..4", open_at); end
    checks++; if (close_at - open_at < 20 || close_at - open_at > 40) begin errors++;
      $display("FAIL t1_door_len: got %0d expected 20..40", close_at - open_at); end
    checks++; if ({moving, door_open, requests} !== 5'b0_0_000) begin errors++;
      $display("FAIL t1_idle_after: got %b expected 00000", {moving, door_open, requests}); end
    checks++; if (dut_vec !== mdl_vec) begin errors++;
      $display("FAIL t1_model: got %b expected %b", dut_vec, mdl_vec); end
  endtask

  task automatic test_travel_up();
    int ticks = 0;
    logic prev;
    press(3'b100);
    checks++; if ({moving, direction} !== 2'b11) begin errors++;
      $display("FAIL t2_start: got %b expected 11", {moving, direction}); end
    prev = tick_clk;
    for (int c = 0; c < 200 && floor !== 2'd1; c++) begin
      @(negedge clk_50); if (tick_clk && !prev) ticks++; prev = tick_clk;
    end
    checks++; if ({floor, door_open, moving} !== 4'b01_0_1 || ticks != 4) begin errors++;
      $display("FAIL t2_floor1: got fl/door/mov %b ticks %0d expected 0101 ticks 4",
               {floor, door_open, moving}, ticks); end
    for (int c = 0; c < 200 && floor !== 2'd2; c++) begin
      @(negedge clk_50); if (tick_clk && !prev) ticks++; prev = tick_clk;
    end
    checks++; if ({door_open, moving, requests} !== 5'b1_0_000 || ticks != 8) begin errors++;
      $display("FAIL t2_floor2: got door/mov/req %b ticks %0d expected 10000 ticks 8",
               {door_open, moving, requests}, ticks); end
    wait_door(1'b0);
    checks++; if (dut_vec !== mdl_vec) begin errors++;
      $display("FAIL t2_model: got %b expected %b", dut_vec, mdl_vec); end
  endtask

  task automatic test_simultaneous_down();
    press(3'b011);
    checks++; if ({moving, direction} !== 2'b10) begin errors++;
      $display("FAIL t3_start: got %b expected 10", {moving, direction}); end
    wait_door(1'b1);
    checks++; if ({floor, requests} !== 5'b01_001) begin errors++;
      $display("FAIL t3_stop1: got %b expected 01001", {floor, requests}); end
    wait_door(1'b0);
    wait_door(1'b1);
    checks++; if ({floor, direction, requests} !== 6'b00_0_000) begin errors++;
      $display("FAIL t3_stop0: got %b expected 000000", {floor, direction, requests}); end
    wait_door(1'b0);
  endtask

  task automatic test_direction_priority();
    press(3'b100);
    checks++; if (direction !== 1'b1) begin errors++;
      $display("FAIL t4_turn_up: got %b expected 1", direction); end
    for (int c = 0; c < 200 && floor !== 2'd1; c++) @(negedge clk_50);
    press(3'b001);
    checks++; if ({floor, moving, requests} !== 6'b01_1_101) begin errors++;
      $display("FAIL t4_latched: got %b expected 011101", {floor, moving, requests}); end
    wait_door(1'b1);
    checks++; if ({floor, direction, requests} !== 6'b10_1_001) begin errors++;
      $display("FAIL t4_top_first: got %b expected 101001", {floor, direction, requests}); end
    wait_door(1'b0);
    for (int c = 0; c < 50 && moving !== 1'b1; c++) @(negedge clk_50);
    checks++; if (direction !== 1'b0) begin errors++;
      $display("FAIL t4_turn_down: got %b expected 0", direction); end
    wait_door(1'b1);
    checks++; if ({floor, requests} !== 5'b00_000) begin errors++;
      $display("FAIL t4_return: got %b expected 00000", {floor, requests}); end
    wait_door(1'b0);
  endtask

  task automatic test_door_restart();
    int rises = 0, press_c = -1, close_c = -1;
    bit saw = 1'b0;
    logic prev;
    press(3'b010);
    wait_door(1'b1);
    checks++; if (floor !== 2'd1) begin errors++;
      $display("FAIL t5_floor: got %0d expected 1", floor); end
    prev = tick_clk;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk_50);
      if (tick_clk && !prev) rises++;
      prev = tick_clk;
      if (rises == 2 && press_c < 0) begin button_n = 3'b101; press_c = c; end
      if (press_c >= 0 && c == press_c + 4) button_n = 3'b111;
      if (requests[1]) saw = 1'b1;
      if (!door_open) begin close_c = c; break; end
    end
    button_n = 3'b111;
    checks++; if (saw !== 1'b0) begin errors++;
      $display("FAIL t5_not_latched: seen %b expected 0", saw); end
    checks++; if (close_c < 35 || close_c > 60) begin errors++;
      $display("FAIL t5_door_len: got %0d expected 35..60", close_c); end
    checks++; if (dut_vec !== mdl_vec) begin errors++;
      $display("FAIL t5_model: got %b expected %b", dut_vec, mdl_vec); end
  endtask

  task automatic test_reset_mid_travel();
    press(3'b100);
    press(3'b001);
    checks++; if ({floor, moving, requests} !== 6'b01_1_101) begin errors++;
      $display("FAIL t6_moving: got %b expected 011101", {floor, moving, requests}); end
    @(negedge clk_50);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (dut_vec !== 8'b00_0_1_0_000) begin errors++;
      $display("FAIL t6_async_reset: got %b expected %b", dut_vec, 8'b00_0_1_0_000); end
    repeat (3) @(negedge clk_50);
    reset_n = 1'b1;
    repeat (50) @(negedge clk_50);
    checks++; if ({floor, moving, door_open, requests} !== 7'b00_0_0_000) begin errors++;
      $display("FAIL t6_after_release: got %b expected 0000000",
               {floor, moving, door_open, requests}); end
    checks++; if (dut_vec !== mdl_vec) begin errors++;
      $display("FAIL t6_model: got %b expected %b", dut_vec, mdl_vec); end
  endtask

  task automatic test_random();
    int hold = 0;
    logic [2:0] m;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_50);
      checks++; if (dut_vec !== mdl_vec) begin errors++;
        $display("FAIL random_cycle %0d: got %b expected %b", c, dut_vec, mdl_vec); end
      checks++; if (floor > 2'd2) begin errors++;
        $display("FAIL floor_range: got %0d expected 0..2", floor); end
      if (hold > 0) begin
        hold--;
        if (hold == 0) button_n = 3'b111;
      end else if ($urandom_range(0, 29) == 0) begin
        m = 3'($urandom_range(1, 7));
        hold = $urandom_range(1, 6);
        button_n = ~m;
      end
    end
    button_n = 3'b111;
  endtask

  initial begin
    test_reset();
    test_single_floor();
    test_travel_up();
    test_simultaneous_down();
    test_direction_priority();
    test_door_restart();
    test_reset_mid_travel();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
